// File: rtl/wb_pipe_reg_pkg.sv
// Shared constants and slot-control helpers for the MEM->WB pipeline register.
package wb_pipe_reg_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [31:0] ZERO_WORD     = 32'h0;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_LOAD  = 2'd1,
    SLOT_CLEAR = 2'd2
  } slot_op_t;

  // A stalled MEM stage feeds a bubble into the youngest slot only; older slots keep draining.
  function automatic slot_op_t slot_op(input logic first, input logic flush,
                                       input logic stall_dn, input logic stall_up);
    if (flush)
      return SLOT_CLEAR;
    else if (stall_dn)
      return SLOT_HOLD;
    else if (stall_up && first)
      return SLOT_CLEAR;
    else
      return SLOT_LOAD;
  endfunction

endpackage

// File: rtl/wb_pipe_reg_if.sv
// MEM->WB bus: write-back request in, registered write-back out, forwarding query.
interface wb_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);

  logic              flush;
  logic              stall_up;
  logic              stall_dn;

  logic              in_valid;
  logic [REG_AW-1:0] in_wd;
  logic [DATA_W-1:0] in_wdata;
  logic              in_wreg;
  logic              in_whilo;
  logic [DATA_W-1:0] in_hi;
  logic [DATA_W-1:0] in_lo;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_wd;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_wreg;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;

  logic [REG_AW-1:0] q_raddr;
  logic              q_hit;
  logic [DATA_W-1:0] q_data;

  modport master (
    output flush, stall_up, stall_dn,
    output in_valid, in_wd, in_wdata, in_wreg, in_whilo, in_hi, in_lo,
    input  wb_valid, wb_wd, wb_wdata, wb_wreg, wb_whilo, wb_hi, wb_lo,
    output q_raddr,
    input  q_hit, q_data
  );

  modport slave (
    input  flush, stall_up, stall_dn,
    input  in_valid, in_wd, in_wdata, in_wreg, in_whilo, in_hi, in_lo,
    output wb_valid, wb_wd, wb_wdata, wb_wreg, wb_whilo, wb_hi, wb_lo,
    input  q_raddr,
    output q_hit, q_data
  );

endinterface

// File: rtl/wb_pipe_slot.sv
// One write-back slot: loads, holds or clears its full payload on each rising edge.
module wb_pipe_slot
  import wb_pipe_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  slot_op_t          op,
  input  logic              load_valid,
  input  logic [REG_AW-1:0] load_wd,
  input  logic [DATA_W-1:0] load_wdata,
  input  logic              load_wreg,
  input  logic              load_whilo,
  input  logic [DATA_W-1:0] load_hi,
  input  logic [DATA_W-1:0] load_lo,
  output logic              valid,
  output logic [REG_AW-1:0] wd,
  output logic [DATA_W-1:0] wdata,
  output logic              wreg,
  output logic              whilo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  always_ff @(posedge clk) begin
    if (rst || op == SLOT_CLEAR) begin
      valid <= 1'b0;
      wd    <= '0;
      wdata <= '0;
      wreg  <= 1'b0;
      whilo <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else if (op == SLOT_LOAD) begin
      valid <= load_valid;
      wd    <= load_wd;
      wdata <= load_wdata;
      wreg  <= load_wreg;
      whilo <= load_whilo;
      hi    <= load_hi;
      lo    <= load_lo;
    end
  end

endmodule

// File: rtl/wb_pipe_reg.sv
// Parametrised MEM->WB pipeline register with stall, bubble, flush and GPR forwarding query.
module wb_pipe_reg
  import wb_pipe_reg_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int STAGES = 1
) (
  input logic          clk,
  input logic          rst,
  wb_pipe_reg_if.slave bus
);

  logic              src_valid [STAGES];
  logic [REG_AW-1:0] src_wd    [STAGES];
  logic [DATA_W-1:0] src_wdata [STAGES];
  logic              src_wreg  [STAGES];
  logic              src_whilo [STAGES];
  logic [DATA_W-1:0] src_hi    [STAGES];
  logic [DATA_W-1:0] src_lo    [STAGES];

  logic              s_valid [STAGES];
  logic [REG_AW-1:0] s_wd    [STAGES];
  logic [DATA_W-1:0] s_wdata [STAGES];
  logic              s_wreg  [STAGES];
  logic              s_whilo [STAGES];
  logic [DATA_W-1:0] s_hi    [STAGES];
  logic [DATA_W-1:0] s_lo    [STAGES];

  logic              hit;
  logic [DATA_W-1:0] hit_data;

  // An invalid MEM result enters as a clean bubble so no stale enables or data leak downstream.
  always_comb begin
    src_valid[0] = bus.in_valid;
    src_wreg[0]  = (bus.in_valid && bus.in_wreg == WRITE_ENABLE) ? WRITE_ENABLE : WRITE_DISABLE;
    src_whilo[0] = (bus.in_valid && bus.in_whilo == WRITE_ENABLE) ? WRITE_ENABLE : WRITE_DISABLE;
    src_wd[0]    = bus.in_valid ? bus.in_wd    : REG_AW'(NOP_REG_ADDR);
    src_wdata[0] = bus.in_valid ? bus.in_wdata : DATA_W'(ZERO_WORD);
    src_hi[0]    = bus.in_valid ? bus.in_hi    : DATA_W'(ZERO_WORD);
    src_lo[0]    = bus.in_valid ? bus.in_lo    : DATA_W'(ZERO_WORD);
    for (int i = 1; i < STAGES; i++) begin
      src_valid[i] = s_valid[i-1];
      src_wd[i]    = s_wd[i-1];
      src_wdata[i] = s_wdata[i-1];
      src_wreg[i]  = s_wreg[i-1];
      src_whilo[i] = s_whilo[i-1];
      src_hi[i]    = s_hi[i-1];
      src_lo[i]    = s_lo[i-1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_slot
    wb_pipe_slot #(
      .DATA_W(DATA_W),
      .REG_AW(REG_AW)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .op         (slot_op(i == 0, bus.flush, bus.stall_dn, bus.stall_up)),
      .load_valid (src_valid[i]),
      .load_wd    (src_wd[i]),
      .load_wdata (src_wdata[i]),
      .load_wreg  (src_wreg[i]),
      .load_whilo (src_whilo[i]),
      .load_hi    (src_hi[i]),
      .load_lo    (src_lo[i]),
      .valid      (s_valid[i]),
      .wd         (s_wd[i]),
      .wdata      (s_wdata[i]),
      .wreg       (s_wreg[i]),
      .whilo      (s_whilo[i]),
      .hi         (s_hi[i]),
      .lo         (s_lo[i])
    );
  end

  // Scan oldest to youngest so the youngest matching slot has the final say.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (s_valid[i] && s_wreg[i] && s_wd[i] == bus.q_raddr &&
          bus.q_raddr != REG_AW'(NOP_REG_ADDR)) begin
        hit      = 1'b1;
        hit_data = s_wdata[i];
      end
    end
  end

  assign bus.q_hit    = hit;
  assign bus.q_data   = hit_data;

  assign bus.wb_valid = s_valid[STAGES-1];
  assign bus.wb_wd    = s_wd[STAGES-1];
  assign bus.wb_wdata = s_wdata[STAGES-1];
  assign bus.wb_wreg  = s_wreg[STAGES-1];
  assign bus.wb_whilo = s_whilo[STAGES-1];
  assign bus.wb_hi    = s_hi[STAGES-1];
  assign bus.wb_lo    = s_lo[STAGES-1];

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Self-checking bench: STAGES=1,2,3 instances share stimulus and are checked against a queue model.
module tb_wb_pipe_reg;

  localparam int NDUT = 3;

  typedef struct {
    bit        valid;
    bit [4:0]  wd;
    bit [31:0] wdata;
    bit        wreg;
    bit        whilo;
    bit [31:0] hi;
    bit [31:0] lo;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, flush, stall_up, stall_dn;
  logic        in_valid, in_wreg, in_whilo;
  logic [4:0]  in_wd, q_raddr;
  logic [31:0] in_wdata, in_hi, in_lo;

  logic        obs_valid [NDUT];
  logic        obs_wreg  [NDUT];
  logic        obs_whilo [NDUT];
  logic        obs_hit   [NDUT];
  logic [4:0]  obs_wd    [NDUT];
  logic [31:0] obs_wdata [NDUT];
  logic [31:0] obs_hi    [NDUT];
  logic [31:0] obs_lo    [NDUT];
  logic [31:0] obs_qdata [NDUT];

  int tests_run    = 0;
  int tests_failed = 0;

  ent_t pipe [NDUT][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    wb_pipe_reg_if #(.DATA_W(32), .REG_AW(5)) bus ();

    assign bus.flush    = flush;
    assign bus.stall_up = stall_up;
    assign bus.stall_dn = stall_dn;
    assign bus.in_valid = in_valid;
    assign bus.in_wd    = in_wd;
    assign bus.in_wdata = in_wdata;
    assign bus.in_wreg  = in_wreg;
    assign bus.in_whilo = in_whilo;
    assign bus.in_hi    = in_hi;
    assign bus.in_lo    = in_lo;
    assign bus.q_raddr  = q_raddr;

    wb_pipe_reg #(.DATA_W(32), .REG_AW(5), .STAGES(g + 1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign obs_valid[g] = bus.wb_valid;
    assign obs_wd[g]    = bus.wb_wd;
    assign obs_wdata[g] = bus.wb_wdata;
    assign obs_wreg[g]  = bus.wb_wreg;
    assign obs_whilo[g] = bus.wb_whilo;
    assign obs_hi[g]    = bus.wb_hi;
    assign obs_lo[g]    = bus.wb_lo;
    assign obs_hit[g]   = bus.q_hit;
    assign obs_qdata[g] = bus.q_data;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setControl(input logic r, input logic f, input logic su, input logic sd);
    rst      = r;
    flush    = f;
    stall_up = su;
    stall_dn = sd;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] wd, input logic [31:0] wdata,
                               input logic wreg, input logic whilo,
                               input logic [31:0] hi, input logic [31:0] lo);
    in_valid = v;
    in_wd    = wd;
    in_wdata = wdata;
    in_wreg  = wreg;
    in_whilo = whilo;
    in_hi    = hi;
    in_lo    = lo;
  endtask

  function automatic ent_t bubble();
    ent_t e;
    e.valid = 0; e.wd = 0; e.wdata = 0; e.wreg = 0; e.whilo = 0; e.hi = 0; e.lo = 0;
    return e;
  endfunction

  function automatic void modelClear();
    for (int g = 0; g < NDUT; g++) begin
      pipe[g].delete();
      for (int j = 0; j <= g; j++) pipe[g].push_back(bubble());
    end
  endfunction

  // Each instance is a FIFO of fixed length: a normal or stalled edge pushes one entry in and
  // retires the oldest; a held edge leaves it untouched.
  function automatic void modelEdge();
    ent_t e;
    if (rst || flush) begin
      modelClear();
      return;
    end
    if (stall_dn) return;
    e = bubble();
    if (!stall_up && in_valid) begin
      e.valid = 1;
      e.wd    = in_wd;
      e.wdata = in_wdata;
      e.wreg  = in_wreg;
      e.whilo = in_whilo;
      e.hi    = in_hi;
      e.lo    = in_lo;
    end
    for (int g = 0; g < NDUT; g++) begin
      pipe[g].push_front(e);
      void'(pipe[g].pop_back());
    end
  endfunction

  function automatic void modelQuery(input int g, output bit hit, output bit [31:0] data);
    hit  = 0;
    data = 0;
    if (q_raddr == 0) return;
    foreach (pipe[g][j]) begin
      if (pipe[g][j].valid && pipe[g][j].wreg && pipe[g][j].wd == q_raddr) begin
        hit  = 1;
        data = pipe[g][j].wdata;
        return;
      end
    end
  endfunction

  task automatic compareModel();
    ent_t      e;
    bit        hit;
    bit [31:0] data;
    for (int g = 0; g < NDUT; g++) begin
      e = pipe[g][pipe[g].size() - 1];
      modelQuery(g, hit, data);
      checkOutput($sformatf("S%0d wb_valid", g + 1), 64'(obs_valid[g]), 64'(e.valid));
      checkOutput($sformatf("S%0d wb_wd", g + 1),    64'(obs_wd[g]),    64'(e.wd));
      checkOutput($sformatf("S%0d wb_wdata", g + 1), 64'(obs_wdata[g]), 64'(e.wdata));
      checkOutput($sformatf("S%0d wb_wreg", g + 1),  64'(obs_wreg[g]),  64'(e.wreg));
      checkOutput($sformatf("S%0d wb_whilo", g + 1), 64'(obs_whilo[g]), 64'(e.whilo));
      checkOutput($sformatf("S%0d wb_hi", g + 1),    64'(obs_hi[g]),    64'(e.hi));
      checkOutput($sformatf("S%0d wb_lo", g + 1),    64'(obs_lo[g]),    64'(e.lo));
      checkOutput($sformatf("S%0d q_hit", g + 1),    64'(obs_hit[g]),   64'(hit));
      checkOutput($sformatf("S%0d q_data", g + 1),   64'(obs_qdata[g]), 64'(data));
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareModel();
  endtask

  task automatic writeReg(input logic [4:0] wd, input logic [31:0] wdata);
    setControl(0, 0, 0, 0);
    applyStimulus(1, wd, wdata, 1, 0, 32'h0, 32'h0);
    step();
  endtask

  task automatic flushAll();
    setControl(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    setControl(0, 0, 0, 0);
  endtask

  initial begin
    modelClear();
    q_raddr = 5'd31;
    setControl(1, 0, 0, 0);
    applyStimulus(1, 5'd31, 32'hFFFF_FFFF, 1, 1, 32'hAAAA_AAAA, 32'h5555_5555);
    @(negedge clk);
    step();
    step();
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("rst S%0d wb_wreg", g + 1),  64'(obs_wreg[g]),  64'd0);
      checkOutput($sformatf("rst S%0d wb_wdata", g + 1), 64'(obs_wdata[g]), 64'd0);
      checkOutput($sformatf("rst S%0d q_hit", g + 1),    64'(obs_hit[g]),   64'd0);
    end

    // single-latch pass-through
    q_raddr = 5'd5;
    writeReg(5'd5, 32'hDEAD_BEEF);
    checkOutput("pass S1 wb_wd",    64'(obs_wd[0]),    64'd5);
    checkOutput("pass S1 wb_wdata", 64'(obs_wdata[0]), 64'hDEAD_BEEF);
    checkOutput("pass S1 wb_wreg",  64'(obs_wreg[0]),  64'd1);

    // MEM stall inserts a bubble behind the in-flight write
    flushAll();
    writeReg(5'd7, 32'h77);
    setControl(0, 0, 1, 0);
    applyStimulus(1, 5'd8, 32'h88, 1, 0, 0, 0);
    step();
    setControl(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("stall_up S3 wb_wd",   64'(obs_wd[2]),   64'd7);
    checkOutput("stall_up S3 wb_wreg", 64'(obs_wreg[2]), 64'd1);
    step();
    checkOutput("bubble S3 wb_wreg", 64'(obs_wreg[2]), 64'd0);
    checkOutput("bubble S3 wb_wd",   64'(obs_wd[2]),   64'd0);

    // WB stall freezes everything, then drains in order
    flushAll();
    for (int k = 1; k <= 3; k++) writeReg(5'(k), 32'h100 + 32'(k));
    checkOutput("fill S3 wb_wd", 64'(obs_wd[2]), 64'd1);
    for (int k = 0; k < 4; k++) begin
      setControl(0, 0, 1'($urandom_range(0, 1)), 1);
      applyStimulus(1, 5'($urandom_range(4, 31)), $urandom, 1, 1, $urandom, $urandom);
      step();
      checkOutput("stall_dn S3 wb_wd",    64'(obs_wd[2]),    64'd1);
      checkOutput("stall_dn S3 wb_wdata", 64'(obs_wdata[2]), 64'h101);
    end
    setControl(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("resume S3 wb_wd #2", 64'(obs_wd[2]), 64'd2);
    step();
    checkOutput("resume S3 wb_wd #3", 64'(obs_wd[2]), 64'd3);

    // flush kills two in-flight writes
    flushAll();
    writeReg(5'd10, 32'hA0);
    writeReg(5'd11, 32'hB0);
    q_raddr = 5'd10;
    #1 checkOutput("pre-flush S2 q_hit 10", 64'(obs_hit[1]), 64'd1);
    flushAll();
    checkOutput("flush S2 wb_wreg", 64'(obs_wreg[1]), 64'd0);
    checkOutput("flush S2 q_hit 10", 64'(obs_hit[1]), 64'd0);
    q_raddr = 5'd11;
    #1 checkOutput("flush S2 q_hit 11", 64'(obs_hit[1]), 64'd0);

    // youngest matching slot wins; register 0 never forwards
    flushAll();
    writeReg(5'd9, 32'h22);
    writeReg(5'd4, 32'h44);
    writeReg(5'd9, 32'h11);
    q_raddr = 5'd9;
    #1;
    checkOutput("fwd S3 q_hit",  64'(obs_hit[2]),   64'd1);
    checkOutput("fwd S3 q_data", 64'(obs_qdata[2]), 64'h11);
    writeReg(5'd0, 32'h55);
    q_raddr = 5'd0;
    #1;
    for (int g = 0; g < NDUT; g++)
      checkOutput($sformatf("fwd r0 S%0d q_hit", g + 1), 64'(obs_hit[g]), 64'd0);

    for (int k = 0; k < 400; k++) begin
      setControl($urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0);
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
      q_raddr = 5'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
